// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//
// Purpose:
//   Shared definitions for the UART receive path: the receiver state
//   encoding, the 16x oversampling tick positions used for bit sampling and
//   decisions, and a 3-input majority helper used to vote mid-bit samples.
//
// Contents:
//   rx_state_e    IDLE / START / DATA / STOP / BREAK
//   SAMPLE_FIRST  first oversampling tick whose line value enters the vote
//   SAMPLE_LAST   last oversampling tick whose line value enters the vote
//   BIT_END       last oversampling tick of a bit period
//   STOP_DECIDE   tick at which the stop bit is judged (early, so that a
//                 start edge directly after the stop bit is not missed)
//   majority3()   2-of-3 vote
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  localparam logic [3:0] SAMPLE_FIRST = 4'd6;
  localparam logic [3:0] SAMPLE_LAST  = 4'd8;
  localparam logic [3:0] BIT_END      = 4'd15;
  localparam logic [3:0] STOP_DECIDE  = 4'd9;

  // True when at least two of the three samples are 1.
  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
//
// Purpose:
//   Two-flop synchroniser for a single asynchronous input. Both flops reset
//   to RESET_VAL so that an idle-high line does not produce a false edge as
//   reset is released. Usable for any slow asynchronous control input.
//
// Ports:
//   clock      in   destination clock
//   reset_n    in   asynchronous active-low reset
//   async_i    in   asynchronous input
//   sync_o     out  synchronised copy of async_i (2 clocks of latency)
// ---------------------------------------------------------------------------
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//
// Purpose:
//   UART receiver driven by a 16x-baud clock enable. Synchronises the serial
//   line, validates the start bit, majority-votes three mid-bit samples per
//   bit, assembles an LSB-first word and reports it with a one-clock strobe.
//   A low stop bit is reported as a framing error, after which the receiver
//   waits for the line to return high before looking for a new start bit.
//   Frame format: 1 start, DATA_BITS data, 1 stop, no parity.
//
// Parameters:
//   DATA_BITS    word length, 5..8
//
// Ports:
//   clock        in   system clock (same clock as the baud generator)
//   reset_n      in   asynchronous active-low reset
//   ce_16        in   16x-baud enable, one clock wide
//   ser_in       in   asynchronous serial line, idles high
//   rx_data      out  last received word, held between frames
//   new_rx_data  out  one-clock strobe: rx_data carries a good word
//   frame_err    out  one-clock strobe: stop bit sampled low
//   rx_busy      out  high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 ce_16,
  input  logic                 ser_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 new_rx_data,
  output logic                 frame_err,
  output logic                 rx_busy
);

  // Index of the final data bit; a 3-bit index covers every legal width.
  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  // -------------------------------------------------------------------------
  // Line synchroniser
  // -------------------------------------------------------------------------
  logic line;

  uart_rx_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .async_i (ser_in),
    .sync_o  (line)
  );

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  rx_state_e            state_q,     state_d;
  logic [3:0]           tick_q,      tick_d;
  logic [2:0]           vote_q,      vote_d;
  logic [2:0]           bit_idx_q,   bit_idx_d;
  logic [DATA_BITS-1:0] shift_q,     shift_d;
  logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
  logic                 new_data_q,  new_data_d;
  logic                 frame_err_q, frame_err_d;

  // Decision helpers shared by the FSM and the datapath.
  logic bit_val;      // majority of the three mid-bit samples
  logic at_bit_end;   // last tick of a bit period
  logic at_stop_dec;  // tick at which the stop bit is judged
  logic in_sample;    // current tick feeds the vote register

  assign bit_val     = majority3(vote_q);
  assign at_bit_end  = (tick_q == BIT_END);
  assign at_stop_dec = (tick_q == STOP_DECIDE);
  assign in_sample   = (tick_q >= SAMPLE_FIRST) && (tick_q <= SAMPLE_LAST);

  // -------------------------------------------------------------------------
  // State register (all sequential state lives here)
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tick_q      <= 4'd0;
      vote_q      <= 3'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      new_data_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      vote_q      <= vote_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      new_data_q  <= new_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (ce_16) begin
      unique case (state_q)
        IDLE: begin
          if (!line) state_d = START;
        end
        START: begin
          // A start bit that reads high at its centre was a glitch.
          if (at_bit_end) state_d = bit_val ? IDLE : DATA;
        end
        DATA: begin
          if (at_bit_end && (bit_idx_q == LAST_IDX)) state_d = STOP;
        end
        STOP: begin
          if (at_stop_dec) state_d = bit_val ? IDLE : BREAK;
        end
        BREAK: begin
          if (line) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Datapath next-state: tick counter, vote, shift register, result strobes
  // -------------------------------------------------------------------------
  always_comb begin
    tick_d      = tick_q;
    vote_d      = vote_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    // Strobes are single-clock: they clear on every clock unless set below.
    new_data_d  = 1'b0;
    frame_err_d = 1'b0;

    if (ce_16) begin
      if (state_q == IDLE) begin
        // Align the oversampling phase to the detected start edge.
        if (!line) tick_d = 4'd0;
      end else begin
        tick_d = tick_q + 4'd1;
        if (in_sample) vote_d = {vote_q[1:0], line};
      end

      unique case (state_q)
        START: begin
          if (at_bit_end && !bit_val) bit_idx_d = 3'd0;
        end
        DATA: begin
          if (at_bit_end) begin
            // LSB arrives first: shift in at the top, so after the last bit
            // the first-received bit has reached position 0.
            shift_d   = {bit_val, shift_q[DATA_BITS-1:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
        STOP: begin
          if (at_stop_dec) begin
            rx_data_d   = shift_q;
            new_data_d  = bit_val;
            frame_err_d = !bit_val;
          end
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    rx_data     = rx_data_q;
    new_rx_data = new_data_q;
    frame_err   = frame_err_q;
    rx_busy     = (state_q != IDLE);
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive stage that sits directly downstream of `baud_gen` and consumes its `ce_16` 16×-baud enable. It synchronises the serial input, detects and validates start bits, majority-votes three mid-bit samples per bit, and delivers each received LSB-first word as a one-clock strobe. A word whose stop bit is low is reported as a framing error, and the block then waits for the line to return high before accepting another start bit.

## Interface
- `DATA_BITS`, default 8: word length; legal range 5..8. Frames are 1 start, `DATA_BITS` data, 1 stop, no parity.
- `clock`  in  1  global clock; the same clock that drives `baud_gen`.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ce_16`  in  1  16×-baud enable from `baud_gen`; one clock wide; may be high on every clock.
- `ser_in`  in  1  asynchronous serial line; idles high.
- `rx_data`  out  `DATA_BITS`  last received word; holds its value between frames.
- `new_rx_data`  out  1  one-clock strobe when `rx_data` is valid.
- `frame_err`  out  1  one-clock strobe when the stop bit sampled low.
- `rx_busy`  out  1  high whenever the state is not IDLE.

## Operation
- `ser_in` passes through a 2-flop synchroniser; both flops reset to 1. Every reference to "line" below means the synchronised value.
- All state, counter and vote updates happen only on clocks where `ce_16` = 1. On other clocks everything holds, except that the strobes clear.
- `tick` is a 4-bit counter that increments mod 16 on each `ce_16` outside IDLE. The line value is shifted into a 3-bit vote register when the pre-increment `tick` is 6, 7 or 8. The majority of the three votes is the bit value.
- IDLE: if the line is 0 on a `ce_16`, set `tick` to 0 and go to START.
- START: at `tick` = 15, a majority of 1 means a glitch: go to IDLE with no output. Otherwise set bit index to 0 and go to DATA.
- DATA: at `tick` = 15, shift the majority into a shift register (LSB first) and increment the bit index. After bit `DATA_BITS`-1, go to STOP.
- STOP: the decision is made at `tick` = 9, so a back-to-back start edge is not missed.
  - Load `rx_data` from the shift register in both cases.
  - Majority 1: pulse `new_rx_data` and go to IDLE.
  - Majority 0: pulse `frame_err` and go to BREAK.
- BREAK: go to IDLE on the first `ce_16` with the line at 1. A held-low line (break condition) therefore yields exactly one `frame_err` and no false frames.
- Reset values: state IDLE, `tick` 0, vote 0, shift register 0, `rx_data` 0, `new_rx_data` 0, `frame_err` 0, `rx_busy` 0.
- Reset asserted mid-frame: the partial word is discarded, no strobe is issued, and reception restarts cleanly after release.

## Timing
- The strobes and `rx_data` are registered. They update on the clock edge that ends the `ce_16` cycle in which STOP makes its decision. Each strobe is high for exactly one clock.
- `new_rx_data` and `frame_err` are never high together.
- Input latency is 2 clocks of synchroniser delay plus up to 1 `ce_16` period to detect the start edge.
- From start-edge detection to the strobe is (1 + `DATA_BITS`) × 16 + 10 `ce_16` ticks, plus one clock.
- `rx_busy` rises on the clock after start detection. It falls with the strobe, or falls at the start-bit glitch reject. It stays high through BREAK.
- The next start bit may be detected on the `ce_16` immediately after the STOP decision.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding (IDLE, START, DATA, STOP, BREAK);
  - constants `SAMPLE_FIRST`=6, `SAMPLE_LAST`=8, `BIT_END`=15, `STOP_DECIDE`=9.
- One sub-module, `uart_rx_sync`: a 2-flop synchroniser with reset value 1, reusable for other asynchronous inputs.
- Majority vote, FSM and shift register stay in `uart_rx`.

## Test plan
- `ce_16` on every clock, 8N1 frame 0x55 at 16 clocks/bit: one `new_rx_data` pulse, `rx_data`=0x55, `frame_err` never high.
- `ce_16` every 3rd clock, frame 0xA3: `rx_data`=0xA3; strobe is exactly 1 clock wide and arrives 154 ticks after start detection.
- Line low for 5 ticks, then high: no strobe; `rx_busy` high then low at START `tick` 15; the following 0x3C frame is received correctly.
- Frame 0x81 with stop bit 0, then line held low for 40 bit times: single `frame_err` pulse, `rx_data`=0x81, no `new_rx_data`, `rx_busy` high until the line returns to 1, then normal reception of 0x7E.
- Back-to-back frames 0x00, 0xFF with no idle gap; one-tick low glitch at `tick` 7 of bit 3 of 0xFF: two `new_rx_data` pulses with data 0x00 and 0xFF, no errors.
- `reset_n` pulsed low during bit 4 of a frame: all outputs 0 immediately; next full frame 0x5A is received correctly with no spurious strobe.
